// File: rtl/nested_scan_seq_pkg.sv
// nested_scan_pkg: shared types and constants for the nested offset-scan sequencer.
// Holds the FSM state enum, the vector/window geometry and the accumulator bias.
// No ports; imported by nested_scan_seq and window_slicer.
package nested_scan_pkg;

  localparam int DATA_W = 512;
  localparam int WIN_W  = 32;
  localparam int OFF_W  = 9;
  localparam int CNT_W  = 16;
  localparam int KMAX   = DATA_W - WIN_W;  // highest legal window offset (480)
  localparam int A_BIAS = 9;               // k0 = a - A_BIAS

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OUTER = 2'd1,
    ST_INNER = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/nested_scan_seq_window_slicer.sv
// window_slicer: combinational extraction of data[off +: WIN_W].
// Ports: data (DATA_W vector), off (OFF_W offset), win (WIN_W window).
// Only offsets 0..KMAX are ever presented; a right shift keeps larger values well-defined.
module window_slicer
  import nested_scan_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  off,
  output logic [WIN_W-1:0]  win
);

  always_comb begin
    win = WIN_W'(data >> off);
  end

endmodule

// File: rtl/nested_scan_seq.sv
// nested_scan_seq: multi-cycle walk of outer index i and inner offset k, emitting one window per (i,k).
// Ports: sysclk/reset (sync, active-high); start + operands captured in IDLE;
// win_valid/win_ready/win_data/win_off window handshake; acc, busy, done status. All outputs registered.
module nested_scan_seq
  import nested_scan_pkg::*;
(
  input  logic              sysclk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  outer_limit,
  input  logic [OFF_W-1:0]  inner_floor,
  input  logic [DATA_W-1:0] data_in,
  input  logic              win_ready,
  output logic              win_valid,
  output logic [WIN_W-1:0]  win_data,
  output logic [OFF_W-1:0]  win_off,
  output logic [31:0]       acc,
  output logic              busy,
  output logic              done
);

  state_t             state;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   limit_q;
  logic [OFF_W-1:0]   floor_q;
  logic [CNT_W-1:0]   i;
  logic [31:0]        a;

  logic [31:0]        a_next;
  logic signed [32:0] k0;
  logic signed [32:0] k_start;
  logic               enter_inner;
  logic               last_outer;
  logic [OFF_W-1:0]   slice_off;
  logic [WIN_W-1:0]   slice_win;

  always_comb begin
    a_next      = a + 32'(i);
    // 33-bit signed so that small accumulators give a negative start offset.
    k0          = $signed({1'b0, a_next}) - $signed(33'(A_BIAS));
    k_start     = (k0 > $signed(33'(KMAX))) ? $signed(33'(KMAX)) : k0;
    enter_inner = k_start >= $signed({{(33 - OFF_W){1'b0}}, floor_q});
    last_outer  = (i == limit_q);
    // The slicer looks one step ahead: the first offset in OUTER, the next (k-1) in INNER.
    slice_off   = (state == ST_OUTER) ? k_start[OFF_W-1:0] : (win_off - OFF_W'(1));
  end

  window_slicer u_slicer (
    .data (data_q),
    .off  (slice_off),
    .win  (slice_win)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      limit_q   <= '0;
      floor_q   <= '0;
      i         <= '0;
      a         <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_off   <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            data_q  <= data_in;
            limit_q <= outer_limit;
            floor_q <= inner_floor;
            a       <= '0;
            i       <= '0;
            busy    <= 1'b1;
            state   <= ST_OUTER;
          end
        end
        ST_OUTER: begin
          a   <= a_next;
          acc <= a_next;
          if (enter_inner) begin
            win_valid <= 1'b1;
            win_off   <= k_start[OFF_W-1:0];
            win_data  <= slice_win;
            state     <= ST_INNER;
          end else if (last_outer) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            i <= i + CNT_W'(1);
          end
        end
        ST_INNER: begin
          if (win_ready) begin
            if (win_off > floor_q) begin
              win_off  <= win_off - OFF_W'(1);
              win_data <= slice_win;
            end else begin
              win_valid <= 1'b0;
              if (last_outer) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                i     <= i + CNT_W'(1);
                state <= ST_OUTER;
              end
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nested_scan_seq.md
# nested_scan_seq

Multi-cycle sequencer for the nested offset-scan datapath: it replaces the single-cycle nested loop with an FSM that walks an outer index `i` and an inner window offset `k`. For each `(i, k)` it extracts one 32-bit window from a captured 512-bit vector and hands it downstream over a valid/ready handshake. A one-cycle `done` pulse marks the end of a run. It sits between the configuration/control logic that issues `start` and the window consumer.

## Interface
- `DATA_W`, 512, width of scanned vector
- `WIN_W`, 32, window width
- `OFF_W`, 9, offset width (log2 `DATA_W`)
- `CNT_W`, 16, outer index width
- `sysclk` in 1: the single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: run request, sampled only in IDLE
- `outer_limit` in `CNT_W`: inclusive upper bound of `i`, captured on start
- `inner_floor` in `OFF_W`: inclusive lower bound of `k`, captured on start
- `data_in` in `DATA_W`: vector to scan, captured on start
- `win_ready` in 1: consumer accepts window
- `win_valid` out 1: window presented
- `win_data` out `WIN_W`: `data_q[win_off +: WIN_W]`
- `win_off` out `OFF_W`: current offset `k`
- `acc` out 32: running accumulator `a`
- `busy` out 1: high from the cycle after start acceptance through the DONE cycle
- `done` out 1: one-cycle completion pulse

## Operation
- **States:** IDLE, OUTER, INNER, DONE.
- **IDLE:**
  - On `start`, capture `data_in`, `outer_limit` and `inner_floor`.
  - Clear `a` and `i`, then go to OUTER.
- **OUTER** (1 cycle):
  - `a_next = a + i`, mod 2^32, unsigned.
  - `k0 = a_next - 9`, signed 33-bit.
  - `kmax = DATA_W - WIN_W` (480).
  - `k_start = min(k0, kmax)`.
  - If `k_start >= inner_floor`, go to INNER with `k = k_start`.
  - Otherwise skip the inner loop. If `i == outer_limit` go to DONE; else `i++` and stay in OUTER.
- **INNER:**
  - `win_valid = 1`, with `win_off = k` and `win_data` registered from the slicer.
  - On `win_valid & win_ready`:
    - If `k > inner_floor`, set `k--` and present the next window in the following cycle.
    - If `k == inner_floor`: when `i == outer_limit` go to DONE; otherwise `i++` and go to OUTER.
- **DONE:** `done = 1` for one cycle, then IDLE.
- Offsets never leave `[inner_floor, 480]`, so no out-of-range slice is ever formed. The `-14` floor case is subsumed, because `inner_floor` is unsigned.
- `i` never exceeds `outer_limit`. `outer_limit = 0` gives exactly one OUTER iteration.
- `acc` reflects `a` as updated in each OUTER cycle and holds its final value after DONE until the next start.
- `start` while busy is ignored, with no effect on captured operands.
- **Reset:** `reset` at any time, including mid-INNER with `win_valid` high, forces IDLE next edge. Outputs go to their reset values: `busy`, `done`, `win_valid` = 0; `win_data`, `win_off`, `acc` = 0. The pending window is dropped.

## Timing
- **Start:** `start` in cycle 0 makes cycle 1 the first OUTER cycle, with `busy = 1` from cycle 1.
- **First window:** earliest `win_valid` is in cycle 2.
- **Backpressure:** while `win_ready = 0`, `win_valid`, `win_off` and `win_data` are held stable. Valid is never withdrawn without a handshake, except on reset.
- **Throughput:** one window per cycle when `win_ready` is held high.
- **Zero-window run:** `done` in cycle `outer_limit + 2`.
- **End of run:** `busy` falls in the cycle after DONE, and a new `start` is accepted in that same cycle.

## Structure
- Package `nested_scan_pkg`:
  - state enum (IDLE/OUTER/INNER/DONE);
  - `DATA_W`, `WIN_W` and `KMAX = DATA_W - WIN_W`;
  - constant `A_BIAS = 9`.
- Sub-module `window_slicer`: combinational `data[off +: WIN_W]` mux over 481 legal offsets. The sequencer registers its output into `win_data`.

## Test plan
- **Zero-window run:** `outer_limit = 3`, `inner_floor = 0`, `start` at cycle 0 -> no `win_valid`; `done` at cycle 5; `acc = 6`; `busy` high for cycles 1–5.
- **Two-window run:** `outer_limit = 4`, `inner_floor = 0`, `data_in = {480'b0, 32'hDEADBEEF}`, `win_ready = 1` -> exactly two windows, in order (off 1, `0x6F56DF77`) then (off 0, `0xDEADBEEF`); `acc = 10`; then `done`.
- **Clamp:** `outer_limit = 32`, `inner_floor = 470` -> iteration `i = 32` (`a = 528`) emits offsets 480 down to 470 (11 windows); no `win_off > 480` ever.
- **Backpressure:** the two-window run with `win_ready` low for 3 cycles at the first window -> `win_off = 1` and `win_data = 0x6F56DF77` held stable for 4 cycles; no window lost or duplicated.
- **Start while busy:** pulse `start` again with different `data_in` mid-INNER -> windows and `acc` unchanged; single `done`.
- **Reset mid-run:** `reset` asserted while `win_valid = 1` -> next cycle all outputs 0, state IDLE; a subsequent start runs cleanly from `a = 0`.
